// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register and instruction fetch with req/ack memory handshake
// Optional feature macro: FETCH_AUTO_INC_EN (accepted fetch also advances pc by one)
module instr_fetch_unit #(
  parameter int AW = 9,
  parameter int DW = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [AW-1:0] i_next_pc,
  input  logic          i_load_pc,
  input  logic          i_fetch_req,
  output logic          o_mem_rd,
  output logic [AW-1:0] o_mem_addr,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ack,
  output logic [AW-1:0] o_pc,
  output logic [DW-1:0] o_ir,
  output logic          o_ir_valid,
  output logic          o_fetch_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    r_state;
  logic [AW-1:0] r_pc;
  logic [DW-1:0] r_ir;
  logic          r_ir_valid;
  logic          r_mem_rd;
  logic [AW-1:0] r_mem_addr;
  logic          r_fetch_busy;

  logic          w_accept;
  logic [AW-1:0] w_pc_after_fetch;

  // A read completes into ir only if it was not cancelled in this same cycle.
  assign w_accept = (r_state == S_REQ) && i_mem_ack && !i_load_pc;

`ifdef FETCH_AUTO_INC_EN
  assign w_pc_after_fetch = r_pc + {{(AW-1){1'b0}}, 1'b1};
`else
  assign w_pc_after_fetch = r_pc;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_ir_valid   <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= '0;
      r_fetch_busy <= 1'b0;
    end else begin
      r_ir_valid <= 1'b0;

      if (i_load_pc)
        r_pc <= i_next_pc;
      else if (w_accept)
        r_pc <= w_pc_after_fetch;

      case (r_state)
        S_IDLE: begin
          if (i_fetch_req) begin
            r_state      <= S_REQ;
            r_mem_rd     <= 1'b1;
            r_fetch_busy <= 1'b1;
            r_mem_addr   <= i_load_pc ? i_next_pc : r_pc;
          end
        end
        S_REQ: begin
          if (i_mem_ack) begin
            r_state      <= S_IDLE;
            r_mem_rd     <= 1'b0;
            r_fetch_busy <= 1'b0;
            if (!i_load_pc) begin
              r_ir       <= i_mem_rdata;
              r_ir_valid <= 1'b1;
            end
          end else if (i_load_pc) begin
            r_state <= S_DRAIN;
          end
        end
        // The cancelled read still has to finish on the bus; its data is dropped.
        S_DRAIN: begin
          if (i_mem_ack) begin
            r_state      <= S_IDLE;
            r_mem_rd     <= 1'b0;
            r_fetch_busy <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_mem_rd     <= 1'b0;
          r_fetch_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_rd     = r_mem_rd;
  assign o_mem_addr   = r_mem_addr;
  assign o_pc         = r_pc;
  assign o_ir         = r_ir;
  assign o_ir_valid   = r_ir_valid;
  assign o_fetch_busy = r_fetch_busy;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - table vectors, hand sequences and random run against a transaction model
// Honours FETCH_AUTO_INC_EN the same way the design does.
module tb_instr_fetch_unit;

`ifdef FETCH_AUTO_INC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  next_pc = '0;
  logic        load_pc = 1'b0;
  logic        fetch_req = 1'b0;
  logic        mem_rd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [8:0]  pc;
  logic [15:0] ir;
  logic        ir_valid;
  logic        fetch_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.AW(9), .DW(16), .RESET_PC(9'h000)) dut (
    .i_clk(clk), .i_reset(reset), .i_next_pc(next_pc), .i_load_pc(load_pc),
    .i_fetch_req(fetch_req), .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack), .o_pc(pc), .o_ir(ir),
    .o_ir_valid(ir_valid), .o_fetch_busy(fetch_busy)
  );

  typedef struct {
    logic rst; logic ld; logic [8:0] npc; logic fr; logic ack; logic [15:0] rdata;
    logic e_rd; logic [8:0] e_addr; logic [8:0] e_pc; logic [15:0] e_ir; logic e_irv; logic e_busy;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(logic rst, logic ld, logic [8:0] npc, logic fr, logic ack,
                              logic [15:0] rdata, logic e_rd, logic [8:0] e_addr, logic [8:0] e_pc,
                              logic [15:0] e_ir, logic e_irv, logic e_busy);
    vec_t v;
    v.rst = rst; v.ld = ld; v.npc = npc; v.fr = fr; v.ack = ack; v.rdata = rdata;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_pc = e_pc; v.e_ir = e_ir; v.e_irv = e_irv; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic ld, input logic [8:0] npc, input logic fr,
                      input logic ack, input logic [15:0] rdata);
    reset = rst; load_pc = ld; next_pc = npc; fetch_req = fr; mem_ack = ack; mem_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_rd, input logic [8:0] e_addr,
                         input logic [8:0] e_pc, input logic [15:0] e_ir, input logic e_irv,
                         input logic e_busy);
    chk({tag, ".mem_rd"}, 32'(mem_rd), 32'(e_rd));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(e_addr));
    chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
    chk({tag, ".ir"}, 32'(ir), 32'(e_ir));
    chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(e_irv));
    chk({tag, ".fetch_busy"}, 32'(fetch_busy), 32'(e_busy));
  endtask

  // Transaction-level reference: one outstanding read, possibly marked cancelled.
  logic        m_out, m_cancel, m_irv;
  logic [8:0]  m_addr, m_pc;
  logic [15:0] m_ir;

  task automatic model(input logic rst, input logic ld, input logic [8:0] npc, input logic fr,
                       input logic ack, input logic [15:0] rdata);
    if (rst) begin
      m_out = 0; m_cancel = 0; m_irv = 0; m_addr = 0; m_pc = 0; m_ir = 0;
    end else begin
      m_irv = 0;
      if (m_out && ack) begin
        if (!m_cancel && !ld) begin
          m_ir = rdata; m_irv = 1; m_pc = m_pc + 9'(INC);
        end
        m_out = 0; m_cancel = 0;
      end else if (m_out && ld) begin
        m_cancel = 1;
      end else if (!m_out && fr) begin
        m_out = 1; m_addr = ld ? npc : m_pc;
      end
      if (ld) m_pc = npc;
    end
  endtask

  initial begin
    logic [8:0] p1, p2, pw;
    int irv_prev;
    p1 = 9'(5 + INC);
    p2 = 9'(5 + 2 * INC);
    pw = 9'(9'h1FF + INC);

    tbl[0]  = mk(1, 0, 9'h000, 0, 0, 16'h0000, 0, 9'h000, 9'h000, 16'h0000, 0, 0);
    tbl[1]  = mk(0, 1, 9'h005, 0, 0, 16'h0000, 0, 9'h000, 9'h005, 16'h0000, 0, 0);
    tbl[2]  = mk(0, 0, 9'h000, 1, 0, 16'h0000, 1, 9'h005, 9'h005, 16'h0000, 0, 1);
    tbl[3]  = mk(0, 0, 9'h000, 0, 1, 16'hA1B2, 0, 9'h005, p1,     16'hA1B2, 1, 0);
    tbl[4]  = mk(0, 0, 9'h000, 0, 0, 16'h0000, 0, 9'h005, p1,     16'hA1B2, 0, 0);
    tbl[5]  = mk(0, 0, 9'h000, 1, 0, 16'h0000, 1, p1,     p1,     16'hA1B2, 0, 1);
    for (int i = 6; i < 10; i++)
      tbl[i] = mk(0, 0, 9'h000, 1, 0, 16'h0000, 1, p1, p1, 16'hA1B2, 0, 1);
    tbl[10] = mk(0, 0, 9'h000, 1, 1, 16'h1234, 0, p1,     p2,     16'h1234, 1, 0);
    tbl[11] = mk(0, 0, 9'h000, 0, 0, 16'h0000, 0, p1,     p2,     16'h1234, 0, 0);
    tbl[12] = mk(0, 1, 9'h003, 0, 0, 16'h0000, 0, p1,     9'h003, 16'h1234, 0, 0);
    tbl[13] = mk(0, 0, 9'h000, 1, 0, 16'h0000, 1, 9'h003, 9'h003, 16'h1234, 0, 1);
    tbl[14] = mk(0, 1, 9'h040, 0, 0, 16'h0000, 1, 9'h003, 9'h040, 16'h1234, 0, 1);
    tbl[15] = mk(0, 0, 9'h000, 0, 0, 16'h0000, 1, 9'h003, 9'h040, 16'h1234, 0, 1);
    tbl[16] = mk(0, 0, 9'h000, 0, 1, 16'hFFFF, 0, 9'h003, 9'h040, 16'h1234, 0, 0);
    tbl[17] = mk(0, 1, 9'h1FF, 1, 0, 16'h0000, 1, 9'h1FF, 9'h1FF, 16'h1234, 0, 1);
    tbl[18] = mk(0, 0, 9'h000, 0, 1, 16'h5A5A, 0, 9'h1FF, pw,     16'h5A5A, 1, 0);
    tbl[19] = mk(0, 0, 9'h000, 1, 0, 16'h0000, 1, pw,     pw,     16'h5A5A, 0, 1);
    tbl[20] = mk(1, 0, 9'h000, 0, 0, 16'h0000, 0, 9'h000, 9'h000, 16'h0000, 0, 0);
    tbl[21] = mk(0, 0, 9'h000, 0, 1, 16'h7777, 0, 9'h000, 9'h000, 16'h0000, 0, 0);
    tbl[22] = mk(0, 0, 9'h000, 1, 0, 16'h0000, 1, 9'h000, 9'h000, 16'h0000, 0, 1);
    tbl[23] = mk(0, 1, 9'h0AA, 0, 1, 16'h1111, 0, 9'h000, 9'h0AA, 16'h0000, 0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].rst, tbl[i].ld, tbl[i].npc, tbl[i].fr, tbl[i].ack, tbl[i].rdata);
      chk_all($sformatf("vec%0d", i), tbl[i].e_rd, tbl[i].e_addr, tbl[i].e_pc,
              tbl[i].e_ir, tbl[i].e_irv, tbl[i].e_busy);
    end

    // Two load_pc pulses during a cancelled read: the later one wins, data dropped.
    step(0, 0, 9'h000, 1, 0, 16'h0000);
    step(0, 1, 9'h010, 0, 0, 16'h0000);
    step(0, 1, 9'h020, 0, 0, 16'h0000);
    chk_all("drain_reload", 1, 9'h0AA, 9'h020, 16'h0000, 0, 1);
    step(0, 0, 9'h000, 1, 1, 16'hBEEF);
    chk_all("drain_done", 0, 9'h0AA, 9'h020, 16'h0000, 0, 0);
    step(0, 0, 9'h000, 0, 1, 16'hCAFE);
    chk_all("idle_ack_ignored", 0, 9'h0AA, 9'h020, 16'h0000, 0, 0);

    // Random traffic against the model; memory may also ack while idle.
    step(1, 0, 9'h000, 0, 0, 16'h0000);
    model(1, 0, 9'h000, 0, 0, 16'h0000);
    irv_prev = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r_rst, r_ld, r_fr, r_ack;
      logic [8:0] r_npc;
      logic [15:0] r_dat;
      r_rst = ($urandom_range(0, 99) == 0);
      r_ld  = ($urandom_range(0, 5) == 0);
      r_fr  = ($urandom_range(0, 2) == 0);
      r_ack = ($urandom_range(0, 2) == 0);
      r_npc = 9'($urandom);
      r_dat = 16'($urandom);
      step(r_rst, r_ld, r_npc, r_fr, r_ack, r_dat);
      model(r_rst, r_ld, r_npc, r_fr, r_ack, r_dat);
      chk_all("rand", m_out, m_addr, m_pc, m_ir, m_irv, m_out);
      chk("rand.irv_back_to_back", 32'(irv_prev != 0 && ir_valid), 32'(0));
      irv_prev = int'(ir_valid);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
